// File: rtl/hex_rotate_ctrl_if.sv
// Signal bundle between the rotation sequencer and its switch/display surroundings.
// The dir signal exists only when HEXROT_DIR_EN is defined.
interface hex_rotate_ctrl_if;
  logic [1:0] u;
  logic [1:0] v;
  logic [1:0] w;
  logic       run;
  logic       step;
`ifdef HEXROT_DIR_EN
  logic       dir;
`endif
  logic [1:0] sel;
  logic [1:0] dig2;
  logic [1:0] dig1;
  logic [1:0] dig0;
  logic [1:0] phase;
  logic       tick;

`ifdef HEXROT_DIR_EN
  modport master (output u, v, w, run, step, dir,
                  input  sel, dig2, dig1, dig0, phase, tick);
  modport slave  (input  u, v, w, run, step, dir,
                  output sel, dig2, dig1, dig0, phase, tick);
`else
  modport master (output u, v, w, run, step,
                  input  sel, dig2, dig1, dig0, phase, tick);
  modport slave  (input  u, v, w, run, step,
                  output sel, dig2, dig1, dig0, phase, tick);
`endif
endinterface

// File: rtl/hex_rotate_ctrl.sv
// Rotation-phase sequencer driving the 3-to-1 character mux select and the HEX2..HEX0 codes.
// Optional macro HEXROT_DIR_EN adds the dir input (1 = reverse rotation).
module hex_rotate_ctrl #(
  parameter int TICK_DIV = 50000000,
  parameter int CNT_W    = 26
) (
  input logic              CLOCK_50,
  input logic              Resetn,
  hex_rotate_ctrl_if.slave bus
);

  localparam logic [0:0]       S_HOLD   = 1'b0;
  localparam logic [0:0]       S_RUN    = 1'b1;
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(TICK_DIV - 1);

  logic [0:0]       state_q, state_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic [1:0]       p_q, p_d;
  logic             tick_q, tick_d;
  logic             run_s1_q, run_s2_q;
  logic             step_s1_q, step_s2_q, step_prev_q;
  logic             step_edge;
  logic             rev;

  function automatic logic [1:0] adv_phase(input logic [1:0] p, input logic reverse);
    logic [1:0] r;
    case (p)
      2'd0:    r = reverse ? 2'd2 : 2'd1;
      2'd1:    r = reverse ? 2'd0 : 2'd2;
      default: r = reverse ? 2'd1 : 2'd0;
    endcase
    return r;
  endfunction

  function automatic logic [1:0] char_at(input logic [1:0] idx, input logic [1:0] a,
                                         input logic [1:0] b, input logic [1:0] c);
    logic [1:0] r;
    case (idx)
      2'd0:    r = a;
      2'd1:    r = b;
      default: r = c;
    endcase
    return r;
  endfunction

`ifdef HEXROT_DIR_EN
  assign rev = bus.dir;
`else
  assign rev = 1'b0;
`endif

  assign step_edge = step_s2_q & ~step_prev_q;

  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    p_d     = p_q;
    tick_d  = 1'b0;
    case (state_q)
      S_HOLD: begin
        cnt_d = '0;
        // Entering RUN takes priority over a coincident step edge.
        if (run_s2_q) begin
          state_d = S_RUN;
        end else if (step_edge) begin
          p_d = adv_phase(p_q, rev);
        end
      end
      S_RUN: begin
        if (cnt_q == CNT_LAST) begin
          cnt_d  = '0;
          p_d    = adv_phase(p_q, rev);
          tick_d = 1'b1;
        end else begin
          cnt_d = cnt_q + 1'b1;
        end
        // A terminal count on the leaving cycle still advances.
        if (!run_s2_q) begin
          state_d = S_HOLD;
          cnt_d   = '0;
        end
      end
      default: begin
        state_d = S_HOLD;
        cnt_d   = '0;
      end
    endcase
  end

  always_ff @(posedge CLOCK_50 or negedge Resetn) begin
    if (!Resetn) begin
      run_s1_q    <= 1'b0;
      run_s2_q    <= 1'b0;
      step_s1_q   <= 1'b0;
      step_s2_q   <= 1'b0;
      step_prev_q <= 1'b0;
      state_q     <= S_HOLD;
      cnt_q       <= '0;
      p_q         <= 2'd0;
      tick_q      <= 1'b0;
    end else begin
      run_s1_q    <= bus.run;
      run_s2_q    <= run_s1_q;
      step_s1_q   <= bus.step;
      step_s2_q   <= step_s1_q;
      step_prev_q <= step_s2_q;
      state_q     <= state_d;
      cnt_q       <= cnt_d;
      p_q         <= p_d;
      tick_q      <= tick_d;
    end
  end

  assign bus.sel   = p_q;
  assign bus.phase = p_q;
  assign bus.tick  = tick_q;
  assign bus.dig2  = char_at(p_q, bus.u, bus.v, bus.w);
  assign bus.dig1  = char_at(adv_phase(p_q, 1'b0), bus.u, bus.v, bus.w);
  assign bus.dig0  = char_at(adv_phase(p_q, 1'b1), bus.u, bus.v, bus.w);

endmodule

// File: tb/tb_hex_rotate_ctrl.sv
// Bench for hex_rotate_ctrl: directed scenarios plus randomized run/step/reset traffic
// compared every cycle against a cycle-history model of the rotation rules.
module tb_hex_rotate_ctrl;
  localparam int TD = 4;

  logic clk = 1'b0;
  logic Resetn = 1'b0;
  always #5 clk = ~clk;

  hex_rotate_ctrl_if bus();

  hex_rotate_ctrl #(.TICK_DIV(TD), .CNT_W(3)) dut (
    .CLOCK_50(clk),
    .Resetn  (Resetn),
    .bus     (bus)
  );

  int checks = 0;
  int failures = 0;
  bit cmp_en = 1'b0;

  task automatic check(input string name, input logic [7:0] act, input logic [7:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got %0d expected %0d at %0t", name, act, exp, $time);
    end
  endtask

  // Reference model: mode, elapsed RUN cycles and phase derived from sampled input history.
  int m_phase = 0;
  bit m_run = 1'b0;
  int m_elapsed = 0;
  bit m_tick = 1'b0;
  bit rq[$];
  bit sq[$];
  bit rs, se;

  function automatic int m_adv(input int p);
`ifdef HEXROT_DIR_EN
    if (bus.dir) return (p + 2) % 3;
`endif
    return (p + 1) % 3;
  endfunction

  function automatic logic [1:0] pick(input int i);
    logic [1:0] chars [3];
    chars[0] = bus.u;
    chars[1] = bus.v;
    chars[2] = bus.w;
    return chars[i % 3];
  endfunction

  always @(posedge clk or negedge Resetn) begin
    if (!Resetn) begin
      m_phase = 0; m_run = 1'b0; m_elapsed = 0; m_tick = 1'b0;
      rq.delete(); sq.delete();
    end else begin
      rs = (rq.size() >= 2) ? rq[1] : 1'b0;
      se = ((sq.size() >= 2) ? sq[1] : 1'b0) && !((sq.size() >= 3) ? sq[2] : 1'b0);
      m_tick = 1'b0;
      if (!m_run) begin
        if (rs) begin
          m_run = 1'b1;
          m_elapsed = 0;
        end else if (se) begin
          m_phase = m_adv(m_phase);
        end
      end else begin
        m_elapsed++;
        if (m_elapsed % TD == 0) begin
          m_tick = 1'b1;
          m_phase = m_adv(m_phase);
        end
        if (!rs) m_run = 1'b0;
      end
      rq.push_front(bus.run);
      sq.push_front(bus.step);
      if (rq.size() > 4) begin
        void'(rq.pop_back());
        void'(sq.pop_back());
      end
    end
  end

  always @(negedge clk) begin
    if (cmp_en) begin
      check("phase", bus.phase, 8'(m_phase));
      check("sel",   bus.sel,   8'(m_phase));
      check("tick",  bus.tick,  8'(m_tick));
      check("dig2",  bus.dig2,  8'(pick(m_phase)));
      check("dig1",  bus.dig1,  8'(pick(m_phase + 1)));
      check("dig0",  bus.dig0,  8'(pick(m_phase + 2)));
    end
  end

  task automatic nxt();
    @(posedge clk);
    #1;
  endtask

  task automatic step_pulse();
    bus.step = 1'b1;
    repeat (3) nxt();
    bus.step = 1'b0;
    repeat (3) nxt();
  endtask

  int tseq [3] = '{2, 0, 1};
  int ntick;
  int last;
  int cnt;

  initial begin
    bus.u = 2'b01; bus.v = 2'b10; bus.w = 2'b00;
    bus.run = 1'b0; bus.step = 1'b0;
`ifdef HEXROT_DIR_EN
    bus.dir = 1'b0;
`endif
    repeat (2) nxt();
    cmp_en = 1'b1;
    check("rst_phase", bus.phase, 8'd0);
    check("rst_sel",   bus.sel,   8'd0);
    check("rst_tick",  bus.tick,  8'd0);
    check("rst_dig2",  bus.dig2,  8'd1);
    check("rst_dig1",  bus.dig1,  8'd2);
    check("rst_dig0",  bus.dig0,  8'd0);
    nxt();
    Resetn = 1'b1;
    repeat (2) nxt();

    // Single steps: update lands on the third edge after step rises.
    bus.step = 1'b1;
    nxt();
    nxt();
    check("step_lat_early", bus.phase, 8'd0);
    nxt();
    check("step1_phase", bus.phase, 8'd1);
    check("step1_dig2", bus.dig2, 8'd2);
    check("step1_dig1", bus.dig1, 8'd0);
    check("step1_dig0", bus.dig0, 8'd1);
    bus.step = 1'b0;
    repeat (3) nxt();
    step_pulse();
    check("step2_phase", bus.phase, 8'd2);
    step_pulse();
    check("step3_phase", bus.phase, 8'd0);

    // Held step advances once.
    bus.step = 1'b1;
    repeat (20) nxt();
    bus.step = 1'b0;
    repeat (4) nxt();
    check("step_held", bus.phase, 8'd1);

    // Auto-rotation with step activity that must be ignored.
    bus.run = 1'b1;
    ntick = 0;
    last = -1;
    for (int i = 0; i < 20; i++) begin
      if (i == 14) bus.run = 1'b0;
      bus.step = (i >= 4 && i < 8);
      nxt();
      if (bus.tick) begin
        if (ntick == 0) check("first_tick_at", 8'(i), 8'd6);
        else check("tick_spacing", 8'(i - last), 8'd4);
        if (ntick < 3) check("tick_phase", bus.phase, 8'(tseq[ntick]));
        last = i;
        ntick++;
      end
    end
    check("tick_count", 8'(ntick), 8'd3);
    check("run_end_phase", bus.phase, 8'd1);

    // Asynchronous reset in RUN with phase 2, prescaler 2.
    bus.run = 1'b1;
    repeat (9) nxt();
    check("pre_reset_phase", bus.phase, 8'd2);
    #2;
    Resetn = 1'b0;
    #1;
    check("mid_rst_phase", bus.phase, 8'd0);
    check("mid_rst_sel",   bus.sel,   8'd0);
    check("mid_rst_tick",  bus.tick,  8'd0);
    check("mid_rst_dig2",  bus.dig2,  8'd1);
    check("mid_rst_dig0",  bus.dig0,  8'd0);
    repeat (2) @(posedge clk);
    #1;
    Resetn = 1'b1;
    cnt = 0;
    while (!bus.tick && cnt < 20) begin
      nxt();
      cnt++;
    end
    check("rerun_first_tick", 8'(cnt), 8'd7);
    bus.run = 1'b0;
    repeat (4) nxt();

`ifdef HEXROT_DIR_EN
    Resetn = 1'b0;
    nxt();
    Resetn = 1'b1;
    bus.dir = 1'b1;
    nxt();
    step_pulse();
    check("rev1_phase", bus.phase, 8'd2);
    step_pulse();
    check("rev2_phase", bus.phase, 8'd1);
    step_pulse();
    check("rev3_phase", bus.phase, 8'd0);
    bus.dir = 1'b0;
`endif

    // Randomized traffic checked by the per-cycle model comparison.
    for (int i = 0; i < 3000; i++) begin
      bus.u = 2'($urandom_range(0, 3));
      bus.v = 2'($urandom_range(0, 3));
      bus.w = 2'($urandom_range(0, 3));
      if ($urandom_range(0, 29) == 0) bus.run = ~bus.run;
      if ($urandom_range(0, 2) == 0) bus.step = ~bus.step;
      if (!Resetn) Resetn = 1'b1;
      else if ($urandom_range(0, 399) == 0) Resetn = 1'b0;
      nxt();
    end
    Resetn = 1'b1;
    repeat (2) nxt();
    cmp_en = 1'b0;

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
